// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared writeback-select codes, load FSM encodings and grant type
package wb_pkg;

  localparam logic [1:0] WB_SEL_REG = 2'b00;
  localparam logic [1:0] WB_SEL_ALU = 2'b10;
  localparam logic [1:0] WB_SEL_MEM = 2'b01;

  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] LD_WAIT = 1'b1;

  typedef logic [4:0] rd_t;

  typedef struct packed {
    logic       valid;
    logic [1:0] sel;
    rd_t        rd;
  } wb_grant_t;

endpackage

// File: rtl/wb_arbiter_if.sv
// rtl/wb_arbiter_if.sv - writeback request/response bundle between pipeline and arbiter
interface wb_arbiter_if;
  import wb_pkg::*;

  logic       alu_valid;
  rd_t        alu_rd;
  logic       lnk_valid;
  rd_t        lnk_rd;
  logic       ld_issue;
  rd_t        ld_rd;
  logic       mem_rvalid;
  logic [1:0] wb_sel;
  logic       rf_we;
  rd_t        rf_waddr;
  logic       stall;
  logic       ld_busy;
  logic       timeout_err;

  modport master (
    output alu_valid, alu_rd, lnk_valid, lnk_rd, ld_issue, ld_rd, mem_rvalid,
    input  wb_sel, rf_we, rf_waddr, stall, ld_busy, timeout_err
  );

  modport slave (
    input  alu_valid, alu_rd, lnk_valid, lnk_rd, ld_issue, ld_rd, mem_rvalid,
    output wb_sel, rf_we, rf_waddr, stall, ld_busy, timeout_err
  );

endinterface

// File: rtl/wb_ld_tracker.sv
// rtl/wb_ld_tracker.sv - single-outstanding load FSM with pending rd
// Optional watchdog under WB_LD_TIMEOUT_EN.
module wb_ld_tracker
  import wb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ld_issue_i,
  input  rd_t  ld_rd_i,
  input  logic mem_rvalid_i,
  output logic ld_busy_o,
  output rd_t  pend_rd_o,
  output logic ret_o,
  output logic ld_stall_o,
  output logic timeout_err_o
);

  logic [0:0] state_q, state_d;
  rd_t        pend_q, pend_d;
  logic       accept;
  logic       expire;

  // A new load may enter only when the slot is free or being freed this cycle.
  assign accept     = ld_issue_i && ((state_q == IDLE) || mem_rvalid_i);
  assign ret_o      = (state_q == LD_WAIT) && mem_rvalid_i;
  assign ld_stall_o = ld_issue_i && !accept;
  assign ld_busy_o  = (state_q == LD_WAIT);
  assign pend_rd_o  = pend_q;

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    if (accept) begin
      state_d = LD_WAIT;
      pend_d  = ld_rd_i;
    end else if (ret_o || expire) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
    end
  end

`ifdef WB_LD_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  assign expire = (state_q == LD_WAIT) && !mem_rvalid_i &&
                  (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    err_d = err_q || expire;
    cnt_d = '0;
    if ((state_d == LD_WAIT) && !accept) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign timeout_err_o = err_q;
`else
  assign expire        = 1'b0;
  assign timeout_err_o = 1'b0;
`endif

endmodule

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - register-file writeback arbiter: load return > link > ALU
// Load watchdog enabled by WB_LD_TIMEOUT_EN.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input logic         clk,
  input logic         rst_n,
  wb_arbiter_if.slave bus
);

  logic      ld_busy, ret, ld_stall, timeout_err;
  rd_t       pend_rd;
  wb_grant_t grant;
  logic      lnk_gnt, alu_gnt, lnk_blk, alu_blk;

  wb_ld_tracker #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_ld_tracker (
    .clk          (clk),
    .rst_n        (rst_n),
    .ld_issue_i   (bus.ld_issue),
    .ld_rd_i      (bus.ld_rd),
    .mem_rvalid_i (bus.mem_rvalid),
    .ld_busy_o    (ld_busy),
    .pend_rd_o    (pend_rd),
    .ret_o        (ret),
    .ld_stall_o   (ld_stall),
    .timeout_err_o(timeout_err)
  );

  // Writes to the outstanding load's rd must wait so the later producer lands last.
  assign lnk_blk = ld_busy && (bus.lnk_rd == pend_rd) && (bus.lnk_rd != '0);
  assign alu_blk = ld_busy && (bus.alu_rd == pend_rd) && (bus.alu_rd != '0);

  always_comb begin
    grant   = '{valid: 1'b0, sel: WB_SEL_REG, rd: 5'd0};
    lnk_gnt = 1'b0;
    alu_gnt = 1'b0;
    if (ret) begin
      grant = '{valid: 1'b1, sel: WB_SEL_MEM, rd: pend_rd};
    end else if (bus.lnk_valid && !lnk_blk) begin
      grant   = '{valid: 1'b1, sel: WB_SEL_REG, rd: bus.lnk_rd};
      lnk_gnt = 1'b1;
    end else if (bus.alu_valid && !bus.lnk_valid && !alu_blk) begin
      grant   = '{valid: 1'b1, sel: WB_SEL_ALU, rd: bus.alu_rd};
      alu_gnt = 1'b1;
    end
  end

  assign bus.stall = rst_n && ((bus.lnk_valid && !lnk_gnt) ||
                               (bus.alu_valid && !alu_gnt) || ld_stall);

  logic [1:0] wb_sel_q, wb_sel_d;
  logic       rf_we_q, rf_we_d;
  rd_t        rf_waddr_q, rf_waddr_d;

  // Grants to x0 are consumed but leave the mux select and address untouched.
  always_comb begin
    rf_we_d    = grant.valid && (grant.rd != '0);
    wb_sel_d   = rf_we_d ? grant.sel : wb_sel_q;
    rf_waddr_d = rf_we_d ? grant.rd  : rf_waddr_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wb_sel_q   <= WB_SEL_REG;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
    end else begin
      wb_sel_q   <= wb_sel_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
    end
  end

  assign bus.wb_sel      = wb_sel_q;
  assign bus.rf_we       = rf_we_q;
  assign bus.rf_waddr    = rf_waddr_q;
  assign bus.ld_busy     = ld_busy;
  assign bus.timeout_err = timeout_err;

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - directed and randomized checks of wb_arbiter (WB_LD_TIMEOUT_EN aware)
module tb_wb_arbiter;
  import wb_pkg::*;

  localparam int TMO = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  wb_arbiter_if bus ();

  wb_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic av, input logic [4:0] ar, input logic lv, input logic [4:0] lr,
                       input logic li, input logic [4:0] lrd, input logic rv);
    bus.alu_valid  = av;
    bus.alu_rd     = ar;
    bus.lnk_valid  = lv;
    bus.lnk_rd     = lr;
    bus.ld_issue   = li;
    bus.ld_rd      = lrd;
    bus.mem_rvalid = rv;
  endtask

  task automatic idle;
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    drive(1'b1, 5'd5, 1'b1, 5'd3, 1'b1, 5'd2, 1'b1);
    tick;
    tick;
    @(negedge clk);
    total++;
    if (bus.stall !== 1'b0) begin
      bad++;
      $display("FAIL reset_stall got=%0b want=0", bus.stall);
    end
    total++;
    if ({bus.rf_we, bus.rf_waddr, bus.wb_sel, bus.ld_busy, bus.timeout_err} !== 10'd0) begin
      bad++;
      $display("FAIL reset_regs got we=%0b addr=%0d sel=%b busy=%0b err=%0b want all 0",
               bus.rf_we, bus.rf_waddr, bus.wb_sel, bus.ld_busy, bus.timeout_err);
    end
    idle;
    tick;
    rst_n = 1'b1;
    tick;
  endtask

  task automatic test_alu_write;
    drive(1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    @(negedge clk);
    total++;
    if (bus.stall !== 1'b0) begin
      bad++;
      $display("FAIL alu_stall got=%0b want=0", bus.stall);
    end
    tick;
    idle;
    total++;
    if ({bus.rf_we, bus.rf_waddr, bus.wb_sel} !== {1'b1, 5'd5, WB_SEL_ALU}) begin
      bad++;
      $display("FAIL alu_write got we=%0b addr=%0d sel=%b want 1/5/10", bus.rf_we, bus.rf_waddr, bus.wb_sel);
    end
    tick;
    total++;
    if ({bus.rf_we, bus.rf_waddr, bus.wb_sel} !== {1'b0, 5'd5, WB_SEL_ALU}) begin
      bad++;
      $display("FAIL idle_hold got we=%0b addr=%0d sel=%b want 0/5/10", bus.rf_we, bus.rf_waddr, bus.wb_sel);
    end
  endtask

  task automatic test_load;
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd7, 1'b0);
    tick;
    idle;
    for (int i = 0; i < 3; i++) begin
      total++;
      if ({bus.ld_busy, bus.rf_we} !== 2'b10) begin
        bad++;
        $display("FAIL load_busy[%0d] got busy=%0b we=%0b want 1/0", i, bus.ld_busy, bus.rf_we);
      end
      if (i == 2) bus.mem_rvalid = 1'b1;
      tick;
    end
    idle;
    total++;
    if ({bus.rf_we, bus.rf_waddr, bus.wb_sel, bus.ld_busy} !== {1'b1, 5'd7, WB_SEL_MEM, 1'b0}) begin
      bad++;
      $display("FAIL load_ret got we=%0b addr=%0d sel=%b busy=%0b want 1/7/01/0",
               bus.rf_we, bus.rf_waddr, bus.wb_sel, bus.ld_busy);
    end
  endtask

  task automatic test_mem_vs_alu;
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd7, 1'b0);
    tick;
    drive(1'b1, 5'd3, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1);
    @(negedge clk);
    total++;
    if (bus.stall !== 1'b1) begin
      bad++;
      $display("FAIL prio_stall got=%0b want=1", bus.stall);
    end
    tick;
    drive(1'b1, 5'd3, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    total++;
    if ({bus.rf_we, bus.rf_waddr, bus.wb_sel} !== {1'b1, 5'd7, WB_SEL_MEM}) begin
      bad++;
      $display("FAIL prio_mem got we=%0b addr=%0d sel=%b want 1/7/01", bus.rf_we, bus.rf_waddr, bus.wb_sel);
    end
    tick;
    idle;
    total++;
    if ({bus.rf_we, bus.rf_waddr, bus.wb_sel} !== {1'b1, 5'd3, WB_SEL_ALU}) begin
      bad++;
      $display("FAIL prio_alu got we=%0b addr=%0d sel=%b want 1/3/10", bus.rf_we, bus.rf_waddr, bus.wb_sel);
    end
  endtask

  task automatic test_waw;
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd9, 1'b0);
    tick;
    drive(1'b1, 5'd9, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if ({bus.stall, bus.rf_we} !== 2'b10) begin
        bad++;
        $display("FAIL waw_hold[%0d] got stall=%0b we=%0b want 1/0", i, bus.stall, bus.rf_we);
      end
      tick;
    end
    bus.mem_rvalid = 1'b1;
    tick;
    bus.mem_rvalid = 1'b0;
    total++;
    if ({bus.rf_we, bus.rf_waddr, bus.wb_sel, bus.stall} !== {1'b1, 5'd9, WB_SEL_MEM, 1'b0}) begin
      bad++;
      $display("FAIL waw_mem got we=%0b addr=%0d sel=%b stall=%0b want 1/9/01/0",
               bus.rf_we, bus.rf_waddr, bus.wb_sel, bus.stall);
    end
    tick;
    idle;
    total++;
    if ({bus.rf_we, bus.rf_waddr, bus.wb_sel} !== {1'b1, 5'd9, WB_SEL_ALU}) begin
      bad++;
      $display("FAIL waw_alu got we=%0b addr=%0d sel=%b want 1/9/10", bus.rf_we, bus.rf_waddr, bus.wb_sel);
    end
  endtask

  task automatic test_rd_zero;
    drive(1'b0, 5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    @(negedge clk);
    total++;
    if (bus.stall !== 1'b0) begin
      bad++;
      $display("FAIL rd0_stall got=%0b want=0", bus.stall);
    end
    tick;
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1);
    total++;
    if ({bus.rf_we, bus.rf_waddr, bus.wb_sel} !== {1'b0, 5'd9, WB_SEL_ALU}) begin
      bad++;
      $display("FAIL rd0_write got we=%0b addr=%0d sel=%b want 0/9/10", bus.rf_we, bus.rf_waddr, bus.wb_sel);
    end
    tick;
    idle;
    total++;
    if ({bus.rf_we, bus.ld_busy} !== 2'b00) begin
      bad++;
      $display("FAIL idle_rvalid got we=%0b busy=%0b want 0/0", bus.rf_we, bus.ld_busy);
    end
  endtask

  task automatic test_back_to_back;
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd4, 1'b0);
    tick;
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd6, 1'b1);
    @(negedge clk);
    total++;
    if (bus.stall !== 1'b0) begin
      bad++;
      $display("FAIL b2b_stall got=%0b want=0", bus.stall);
    end
    tick;
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd8, 1'b0);
    total++;
    if ({bus.rf_we, bus.rf_waddr, bus.wb_sel, bus.ld_busy} !== {1'b1, 5'd4, WB_SEL_MEM, 1'b1}) begin
      bad++;
      $display("FAIL b2b_first got we=%0b addr=%0d sel=%b busy=%0b want 1/4/01/1",
               bus.rf_we, bus.rf_waddr, bus.wb_sel, bus.ld_busy);
    end
    @(negedge clk);
    total++;
    if (bus.stall !== 1'b1) begin
      bad++;
      $display("FAIL ld_in_wait_stall got=%0b want=1", bus.stall);
    end
    tick;
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1);
    tick;
    idle;
    total++;
    if ({bus.rf_we, bus.rf_waddr, bus.wb_sel, bus.ld_busy} !== {1'b1, 5'd6, WB_SEL_MEM, 1'b0}) begin
      bad++;
      $display("FAIL b2b_second got we=%0b addr=%0d sel=%b busy=%0b want 1/6/01/0",
               bus.rf_we, bus.rf_waddr, bus.wb_sel, bus.ld_busy);
    end
  endtask

  task automatic test_reset_midload;
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd11, 1'b0);
    tick;
    idle;
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    bus.mem_rvalid = 1'b1;
    tick;
    idle;
    total++;
    if ({bus.rf_we, bus.ld_busy} !== 2'b00) begin
      bad++;
      $display("FAIL reset_midload got we=%0b busy=%0b want 0/0", bus.rf_we, bus.ld_busy);
    end
  endtask

  task automatic test_timeout;
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd12, 1'b0);
    tick;
    idle;
`ifdef WB_LD_TIMEOUT_EN
    repeat (TMO - 1) tick;
    total++;
    if ({bus.ld_busy, bus.timeout_err, bus.rf_we} !== 3'b100) begin
      bad++;
      $display("FAIL tmo_before got busy=%0b err=%0b we=%0b want 1/0/0", bus.ld_busy, bus.timeout_err, bus.rf_we);
    end
    tick;
    total++;
    if ({bus.ld_busy, bus.timeout_err, bus.rf_we} !== 3'b010) begin
      bad++;
      $display("FAIL tmo_fire got busy=%0b err=%0b we=%0b want 0/1/0", bus.ld_busy, bus.timeout_err, bus.rf_we);
    end
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    total++;
    if (bus.timeout_err !== 1'b0) begin
      bad++;
      $display("FAIL tmo_clear got=%0b want=0", bus.timeout_err);
    end
`else
    repeat (2 * TMO) tick;
    total++;
    if ({bus.ld_busy, bus.timeout_err} !== 2'b10) begin
      bad++;
      $display("FAIL no_tmo got busy=%0b err=%0b want 1/0", bus.ld_busy, bus.timeout_err);
    end
    bus.mem_rvalid = 1'b1;
    tick;
    idle;
    total++;
    if ({bus.rf_we, bus.rf_waddr, bus.ld_busy} !== {1'b1, 5'd12, 1'b0}) begin
      bad++;
      $display("FAIL late_ret got we=%0b addr=%0d busy=%0b want 1/12/0", bus.rf_we, bus.rf_waddr, bus.ld_busy);
    end
`endif
  endtask

  // Requesters hold until the model says they were served; the model tracks
  // one outstanding load and the last completed register write.
  task automatic test_random;
    logic       a_v = 0, l_v = 0, li = 0;
    logic [4:0] a_rd = 0, l_rd = 0, li_rd = 0;
    logic       m_busy = 0, m_we = 0, m_err = 0;
    logic [4:0] m_pend = 0, m_addr = 0;
    logic [1:0] m_sel = WB_SEL_REG;
    int         m_wait = 0;
    rst_n = 1'b0;
    idle;
    tick;
    rst_n = 1'b1;
    for (int c = 0; c < 400; c++) begin
      logic rv, ret, lg, ag, acc, g_any, exp_stall;
      logic [4:0] g_rd;
      logic [1:0] g_sel;
      if (!a_v && $urandom_range(0, 99) < 45) begin a_v = 1; a_rd = 5'($urandom_range(0, 7)); end
      if (!l_v && $urandom_range(0, 99) < 25) begin l_v = 1; l_rd = 5'($urandom_range(0, 7)); end
      if (!li && $urandom_range(0, 99) < 20) begin li = 1; li_rd = 5'($urandom_range(0, 7)); end
      rv = ($urandom_range(0, 99) < 30);
      drive(a_v, a_rd, l_v, l_rd, li, li_rd, rv);

      ret = m_busy && rv;
      lg = 0; ag = 0; g_any = 0; g_rd = 0; g_sel = WB_SEL_REG;
      if (ret) begin
        g_any = 1; g_rd = m_pend; g_sel = WB_SEL_MEM;
      end else if (l_v && !(m_busy && l_rd == m_pend && l_rd != 0)) begin
        g_any = 1; g_rd = l_rd; g_sel = WB_SEL_REG; lg = 1;
      end else if (a_v && !l_v && !(m_busy && a_rd == m_pend && a_rd != 0)) begin
        g_any = 1; g_rd = a_rd; g_sel = WB_SEL_ALU; ag = 1;
      end
      acc = li && (!m_busy || rv);
      exp_stall = (l_v && !lg) || (a_v && !ag) || (li && !acc);

      @(negedge clk);
      total++;
      if (bus.stall !== exp_stall) begin
        bad++;
        $display("FAIL rnd_stall[%0d] got=%0b want=%0b", c, bus.stall, exp_stall);
      end
      tick;

      m_we = g_any && g_rd != 0;
      if (m_we) begin m_sel = g_sel; m_addr = g_rd; end
      if (acc) begin
        m_busy = 1; m_pend = li_rd; m_wait = 0;
      end else if (ret) begin
        m_busy = 0;
      end else if (m_busy) begin
`ifdef WB_LD_TIMEOUT_EN
        m_wait++;
        if (m_wait == TMO) begin m_busy = 0; m_err = 1; m_wait = 0; end
`endif
      end
      if (lg) l_v = 0;
      if (ag) a_v = 0;
      if (acc) li = 0;

      total++;
      if ({bus.rf_we, bus.rf_waddr, bus.wb_sel, bus.ld_busy, bus.timeout_err} !==
          {m_we, m_addr, m_sel, m_busy, m_err}) begin
        bad++;
        $display("FAIL rnd_out[%0d] got we=%0b addr=%0d sel=%b busy=%0b err=%0b want we=%0b addr=%0d sel=%b busy=%0b err=%0b",
                 c, bus.rf_we, bus.rf_waddr, bus.wb_sel, bus.ld_busy, bus.timeout_err,
                 m_we, m_addr, m_sel, m_busy, m_err);
      end
    end
    idle;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    idle;
    rst_n = 1'b0;
    tick;
    test_reset;
    test_alu_write;
    test_load;
    test_mem_vs_alu;
    test_waw;
    test_rd_zero;
    test_back_to_back;
    test_reset_midload;
    test_timeout;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 64, meaning: load-return watchdog limit in cycles (only used when WB_LD_TIMEOUT_EN is defined).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 alu_valid  input  1  ALU result ready for writeback this cycle.
REQ-005 alu_rd  input  5  ALU destination register.
REQ-006 lnk_valid  input  1  link/register-source writeback request (PC+4 or forwarded register).
REQ-007 lnk_rd  input  5  link destination register.
REQ-008 ld_issue  input  1  load issued to data memory this cycle.
REQ-009 ld_rd  input  5  load destination register.
REQ-010 mem_rvalid  input  1  data-memory read data returns this cycle.
REQ-011 wb_sel  output  2  writeback mux select: 2'b00 register/link, 2'b10 ALU, 2'b01 memory.
REQ-012 rf_we  output  1  register-file write enable.
REQ-013 rf_waddr  output  5  register-file write address.
REQ-014 stall  output  1  upstream holds its current request; combinational.
REQ-015 ld_busy  output  1  one load outstanding.
REQ-016 timeout_err  output  1  sticky load-timeout flag.

Function
REQ-017 wb_sel, rf_we, rf_waddr SHALL be registered: a grant decided in cycle N drives them in cycle N+1.
REQ-018 Grant priority SHALL be: load return (mem_rvalid in LD_WAIT) > lnk_valid > alu_valid; exactly one write per cycle.
REQ-019 A non-granted valid request SHALL raise stall in that cycle; the requester holds valid/rd until granted.
REQ-020 Load FSM: IDLE -> LD_WAIT on ld_issue (capture ld_rd); LD_WAIT -> IDLE on mem_rvalid (grant memory writeback to captured rd).
REQ-021 ld_issue in LD_WAIT SHALL assert stall and be ignored; at most one load outstanding.
REQ-022 ld_issue coinciding with mem_rvalid in LD_WAIT: return completes, FSM stays LD_WAIT for the new load, no stall.
REQ-023 mem_rvalid in IDLE SHALL be ignored (no write, no state change).
REQ-024 In LD_WAIT, alu_valid or lnk_valid whose rd equals the pending load rd (rd != 0) SHALL stall until the load returns (WAW ordering).
REQ-025 A granted request with rd == 0 SHALL complete (consume, deassert stall) with rf_we = 0.
REQ-026 When no write is granted, rf_we = 0; wb_sel and rf_waddr hold previous values.
REQ-027 ld_busy = 1 exactly while in LD_WAIT.

Reset
REQ-028 With rst_n = 0 at a clock edge: FSM -> IDLE, pending rd = 0, wb_sel = 2'b00, rf_we = 0, rf_waddr = 0, timeout_err = 0, counter = 0.
REQ-029 Reset mid-load SHALL abandon the load; a later mem_rvalid is ignored per REQ-023.
REQ-030 stall SHALL be 0 while rst_n = 0.

Configuration
REQ-031 Macro WB_LD_TIMEOUT_EN defined: a counter runs in LD_WAIT; after TIMEOUT_CYCLES cycles without mem_rvalid, FSM -> IDLE with no write and timeout_err set (sticky until reset).
REQ-032 WB_LD_TIMEOUT_EN undefined: no counter; LD_WAIT waits indefinitely; timeout_err tied to 0.

Structure
REQ-033 Shared package wb_pkg SHALL hold WB_SEL_REG = 2'b00, WB_SEL_ALU = 2'b10, WB_SEL_MEM = 2'b01 and the FSM state encodings IDLE and LD_WAIT.
REQ-034 Sub-module wb_ld_tracker SHALL contain the load FSM, pending-rd register and timeout counter; wb_arbiter contains grant, stall and output registers.

Verification
REQ-035 alu_valid = 1, alu_rd = 5 in IDLE -> next cycle rf_we = 1, rf_waddr = 5, wb_sel = 2'b10; stall = 0.
REQ-036 ld_issue with ld_rd = 7; mem_rvalid 3 cycles later -> ld_busy high 3 cycles; then rf_we = 1, rf_waddr = 7, wb_sel = 2'b01.
REQ-037 In LD_WAIT (rd = 7), mem_rvalid and alu_valid (rd = 3) in the same cycle -> memory write to 7 first, stall = 1; ALU write to 3 the following cycle.
REQ-038 In LD_WAIT (rd = 9), alu_valid with rd = 9 -> stall held until mem_rvalid; writes in order 9 (mem), then 9 (ALU).
REQ-039 lnk_valid rd = 0 -> stall = 0, rf_we stays 0; mem_rvalid in IDLE -> no write.
REQ-040 WB_LD_TIMEOUT_EN, TIMEOUT_CYCLES = 4: ld_issue, no return -> after 4 cycles timeout_err = 1, ld_busy = 0, no write; rst_n = 0 clears timeout_err.
